// File: rtl/jtpopeye_vtimer.sv
// Parametrised video timing generator: pixel/line counters, flipped coordinates, blanking, sync, DMA window and frame pulse.
// Optional line-compare interrupt enabled by defining JTPOPEYE_LINE_IRQ_EN.
module jtpopeye_vtimer #(
  parameter int HW          = 9,
  parameter int VW          = 9,
  parameter int H_TOTAL     = 384,
  parameter int V_TOTAL     = 264,
  parameter int HB_START    = 256,
  parameter int HB_END      = 0,
  parameter int VB_START    = 240,
  parameter int VB_END      = 16,
  parameter int HS_START    = 304,
  parameter int HS_END      = 336,
  parameter int VS_START    = 248,
  parameter int VS_END      = 251,
  parameter int DMA_LEN     = 64,
  parameter int H_FLIP_KEEP = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          flip,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hb,
  output logic          vb,
  output logic          hs,
  output logic          vs,
  output logic          hbd_n,
  output logic          frame
`ifdef JTPOPEYE_LINE_IRQ_EN
  ,
  input  logic [VW-1:0] irq_line,
  input  logic          irq_ack,
  output logic          irq
`endif
);

  localparam int DW = (DMA_LEN > 0) ? $clog2(DMA_LEN + 1) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HBS    = HW'(HB_START);
  localparam logic [HW-1:0] HBE    = HW'(HB_END);
  localparam logic [HW-1:0] HSS    = HW'(HS_START);
  localparam logic [HW-1:0] HSE    = HW'(HS_END);
  localparam logic [VW-1:0] VBS    = VW'(VB_START);
  localparam logic [VW-1:0] VBE    = VW'(VB_END);
  localparam logic [VW-1:0] VSS    = VW'(VS_START);
  localparam logic [VW-1:0] VSE    = VW'(VS_END);
  localparam logic [DW-1:0] DMA_LOAD = (DMA_LEN > 0) ? DW'(DMA_LEN - 1) : '0;

  localparam bit PARAM_BAD =
      (HB_START >= H_TOTAL) || (HB_END >= H_TOTAL) ||
      (HS_START >= H_TOTAL) || (HS_END >= H_TOTAL) ||
      (VB_START >= V_TOTAL) || (VB_END >= V_TOTAL) ||
      (VS_START >= V_TOTAL) || (VS_END >= V_TOTAL) ||
      (DMA_LEN > H_TOTAL) || (H_TOTAL > (1 << HW)) || (V_TOTAL > (1 << VW));

  if (PARAM_BAD) begin : g_param_error
    $error("jtpopeye_vtimer: timing parameter out of range");
  end

  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          line_adv;
  logic [DW-1:0] dma_cnt_reg;

  always_comb begin
    line_adv = (hcnt == H_LAST);
    h_next   = line_adv ? '0 : hcnt + 1'b1;
    v_next   = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
  end

  // Flags are derived from the next count so they switch together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hb          <= 1'b1;
      vb          <= 1'b1;
      hs          <= 1'b0;
      vs          <= 1'b0;
      hbd_n       <= 1'b1;
      frame       <= 1'b0;
      dma_cnt_reg <= '0;
    end else if (pxl_cen) begin
      hcnt  <= h_next;
      frame <= 1'b0;

      if (h_next == HBS)      hb <= 1'b1;
      else if (h_next == HBE) hb <= 1'b0;

      if (h_next == HSS)      hs <= 1'b1;
      else if (h_next == HSE) hs <= 1'b0;

      if (line_adv) begin
        vcnt <= v_next;
        if (v_next == VBS) begin
          vb <= 1'b1;
          if (!vb) frame <= 1'b1;
        end else if (v_next == VBE) begin
          vb <= 1'b0;
        end
        if (v_next == VSS)      vs <= 1'b1;
        else if (v_next == VSE) vs <= 1'b0;
      end

      // DMA window closes after DMA_LEN cens or early when blanking ends.
      if (h_next == HBS) begin
        hbd_n       <= (DMA_LEN == 0);
        dma_cnt_reg <= DMA_LOAD;
      end else if (!hbd_n) begin
        if (dma_cnt_reg == '0 || h_next == HBE) hbd_n <= 1'b1;
        else dma_cnt_reg <= dma_cnt_reg - 1'b1;
      end
    end
  end

  always_comb begin
    h = hcnt ^ {{(HW - H_FLIP_KEEP){flip}}, {H_FLIP_KEEP{1'b0}}};
    v = vcnt ^ {VW{flip}};
  end

`ifdef JTPOPEYE_LINE_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (pxl_cen && line_adv && v_next == irq_line) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_jtpopeye_vtimer.sv
// Directed bench for jtpopeye_vtimer; vertical timing shortened (40 lines) to keep frame runs short.
// Exercises the line interrupt too when JTPOPEYE_LINE_IRQ_EN is defined.
module tb_jtpopeye_vtimer;
  localparam int HW = 9;
  localparam int VW = 9;

  logic          clk = 1'b0;
  logic          rst, pxl_cen, flip;
  logic [HW-1:0] hcnt, h;
  logic [VW-1:0] vcnt, v;
  logic          hb, vb, hs, vs, hbd_n, frame;
  logic [VW-1:0] irq_line;
  logic          irq_ack;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  jtpopeye_vtimer #(
    .HW(HW), .VW(VW), .H_TOTAL(384), .V_TOTAL(40),
    .HB_START(256), .HB_END(0), .VB_START(30), .VB_END(4),
    .HS_START(304), .HS_END(336), .VS_START(33), .VS_END(35),
    .DMA_LEN(64), .H_FLIP_KEEP(3)
  ) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip(flip),
    .hcnt(hcnt), .vcnt(vcnt), .h(h), .v(v),
    .hb(hb), .vb(vb), .hs(hs), .vs(vs), .hbd_n(hbd_n), .frame(frame)
`ifdef JTPOPEYE_LINE_IRQ_EN
    , .irq_line(irq_line), .irq_ack(irq_ack), .irq(irq)
`endif
  );

`ifndef JTPOPEYE_LINE_IRQ_EN
  assign irq = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pxl_cen = 1'b1; flip = 1'b0; irq_line = '0; irq_ack = 1'b0;
    repeat (3) tick();
    vectors++; if (hcnt !== 9'd0)  begin miscompares++; $display("FAIL reset_hcnt got %0d want 0", hcnt); end
    vectors++; if (vcnt !== 9'd0)  begin miscompares++; $display("FAIL reset_vcnt got %0d want 0", vcnt); end
    vectors++; if ({hb, vb, hs, vs, hbd_n, frame, irq} !== 7'b1100100)
      begin miscompares++; $display("FAIL reset_flags got %b want 1100100 (hb vb hs vs hbd_n frame irq)", {hb, vb, hs, vs, hbd_n, frame, irq}); end
    rst = 1'b0;
    tick();
    vectors++; if (hcnt !== 9'd1)  begin miscompares++; $display("FAIL first_cen_hcnt got %0d want 1", hcnt); end
    $display("reset: hcnt=%0d vcnt=%0d after release", hcnt, vcnt);
  endtask

  task automatic test_line();
    int n = 0, hs_n = 0, dma_n = 0, hb_n = 0;
    while (hcnt !== 9'd383 && n < 1000) begin tick(); n++; end
    tick();
    vectors++; if (hcnt !== 9'd0 || vcnt !== 9'd1)
      begin miscompares++; $display("FAIL hwrap got h=%0d v=%0d want h=0 v=1", hcnt, vcnt); end
    for (int i = 0; i < 384; i++) begin
      vectors++; if (hcnt !== 9'(i)) begin miscompares++; $display("FAIL line_hcnt got %0d want %0d", hcnt, i); end
      vectors++; if (hb !== (i >= 256)) begin miscompares++; $display("FAIL line_hb at hcnt=%0d got %b", i, hb); end
      vectors++; if (hs !== (i >= 304 && i <= 335)) begin miscompares++; $display("FAIL line_hs at hcnt=%0d got %b", i, hs); end
      vectors++; if (hbd_n !== !(i >= 256 && i <= 319)) begin miscompares++; $display("FAIL line_hbd_n at hcnt=%0d got %b", i, hbd_n); end
      hs_n  += int'(hs);
      dma_n += int'(!hbd_n);
      hb_n  += int'(hb);
      tick();
    end
    vectors++; if (hs_n != 32)  begin miscompares++; $display("FAIL hs_width got %0d want 32", hs_n); end
    vectors++; if (dma_n != 64) begin miscompares++; $display("FAIL dma_width got %0d want 64", dma_n); end
    vectors++; if (hb_n != 128) begin miscompares++; $display("FAIL hb_width got %0d want 128", hb_n); end
    $display("line: hs=%0d dma=%0d hb=%0d cens", hs_n, dma_n, hb_n);
  endtask

  task automatic test_frame();
    int n = 0, frame_n = 0, frame_v = -1, frame_h = -1;
    int pv = 0, ph = 0;
    do begin
      vectors++; if (vb !== (vcnt >= 30 || vcnt < 4)) begin miscompares++; $display("FAIL frame_vb at v=%0d h=%0d got %b", vcnt, hcnt, vb); end
      vectors++; if (vs !== (vcnt >= 33 && vcnt <= 34)) begin miscompares++; $display("FAIL frame_vs at v=%0d h=%0d got %b", vcnt, hcnt, vs); end
      if (frame) begin frame_n++; frame_v = int'(vcnt); frame_h = int'(hcnt); end
      pv = int'(vcnt); ph = int'(hcnt);
      tick(); n++;
    end while (!(vcnt == 9'd0 && hcnt == 9'd0) && n < 20000);
    vectors++; if (n >= 20000) begin miscompares++; $display("FAIL frame_timeout got %0d cens want < 20000", n); end
    vectors++; if (pv != 39 || ph != 383) begin miscompares++; $display("FAIL vwrap got from v=%0d h=%0d want v=39 h=383", pv, ph); end
    vectors++; if (frame_n != 1) begin miscompares++; $display("FAIL frame_count got %0d want 1", frame_n); end
    vectors++; if (frame_v != 30 || frame_h != 0) begin miscompares++; $display("FAIL frame_pos got v=%0d h=%0d want v=30 h=0", frame_v, frame_h); end
    $display("frame: pulse count=%0d at v=%0d h=%0d", frame_n, frame_v, frame_h);
  endtask

  task automatic test_flip();
    int n = 0;
    while (!(vcnt == 9'd5 && hcnt == 9'h10A) && n < 20000) begin tick(); n++; end
    vectors++; if (n >= 20000) begin miscompares++; $display("FAIL flip_seek timeout got v=%0d h=%0d want v=5 h=266", vcnt, hcnt); end
    pxl_cen = 1'b0;
    flip = 1'b1;
    #1;
    vectors++; if (h !== 9'h0F2) begin miscompares++; $display("FAIL flip_h got %h want 0f2", h); end
    vectors++; if (v !== 9'h1FA) begin miscompares++; $display("FAIL flip_v got %h want 1fa", v); end
    tick();
    vectors++; if (hcnt !== 9'h10A || vcnt !== 9'h005)
      begin miscompares++; $display("FAIL flip_hold got h=%h v=%h want h=10a v=005", hcnt, vcnt); end
    flip = 1'b0;
    #1;
    vectors++; if (h !== 9'h10A || v !== 9'h005) begin miscompares++; $display("FAIL unflip got h=%h v=%h want 10a 005", h, v); end
    $display("flip: h=%h v=%h", h, v);
  endtask

  task automatic test_half_cen_reset();
    int n = 0;
    do begin
      pxl_cen = ~pxl_cen;
      tick(); n++;
    end while (!(hcnt == 9'd100 && pxl_cen) && n < 2000);
    vectors++; if (hcnt !== 9'd100) begin miscompares++; $display("FAIL half_seek got %0d want 100", hcnt); end
    pxl_cen = 1'b0;
    tick();
    vectors++; if (hcnt !== 9'd100) begin miscompares++; $display("FAIL cen_hold got %0d want 100", hcnt); end
    rst = 1'b1;
    tick();
    vectors++; if (hcnt !== 9'd0 || vcnt !== 9'd0) begin miscompares++; $display("FAIL midreset_cnt got h=%0d v=%0d want 0 0", hcnt, vcnt); end
    vectors++; if ({hb, vb, hbd_n, frame} !== 4'b1110) begin miscompares++; $display("FAIL midreset_flags got %b want 1110", {hb, vb, hbd_n, frame}); end
    rst = 1'b0; pxl_cen = 1'b1;
    tick();
    vectors++; if (hcnt !== 9'd1 || vcnt !== 9'd0) begin miscompares++; $display("FAIL resume got h=%0d v=%0d want 1 0", hcnt, vcnt); end
    $display("half_cen_reset: resumed at h=%0d v=%0d", hcnt, vcnt);
  endtask

`ifdef JTPOPEYE_LINE_IRQ_EN
  task automatic test_irq();
    int n = 0;
    irq_line = 9'd10;
    while (!irq && n < 20000) begin tick(); n++; end
    vectors++; if (vcnt !== 9'd10 || hcnt !== 9'd0) begin miscompares++; $display("FAIL irq_pos got v=%0d h=%0d want v=10 h=0", vcnt, hcnt); end
    pxl_cen = 1'b0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_ack got %b want 0", irq); end
    irq_line = 9'd11; pxl_cen = 1'b1; n = 0;
    while (hcnt !== 9'd383 && n < 1000) begin tick(); n++; end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    vectors++; if (irq !== 1'b1 || vcnt !== 9'd11) begin miscompares++; $display("FAIL irq_set_wins got irq=%b v=%0d want 1 11", irq, vcnt); end
    $display("irq: irq=%b at v=%0d", irq, vcnt);
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_flip();
    test_half_cen_reset();
`ifdef JTPOPEYE_LINE_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
